// File: rtl/datapath_controller.sv
// datapath_controller: multi-cycle instruction controller for a small
// register-file/ALU/data-memory datapath. Accepts one 16-bit instruction
// at a time, sequences it through DECODE/EXEC/MEM/WB and raises the
// register-file, flag and memory strobes for it.
//
// Handshake: an instruction is taken on a rising edge where
// instr_valid & instr_ready are both 1. instr_ready is high only while the
// controller sits in IDLE (and never while rst is held low). The producer
// must keep instr stable while instr_valid is high and not yet accepted.
module datapath_controller #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  rdest_addr,
    output logic [3:0]  rsrc_addr,
    output logic [2:0]  alu_op,
    output logic        reg_wr_en,
    output logic        wb_sel,
    output logic        flag_wr_en,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic        illegal,
    output logic        halted,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_ALU  = 3'd0,
        K_LOAD = 3'd1,
        K_STOR = 3'd2,
        K_EOF  = 3'd3,
        K_ILL  = 3'd4
    } kind_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t      state;
    kind_t       kind_q;
    logic [15:0] ir;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        alu_wr_q;
    logic        alu_fw_q;
    logic [2:0]  alu_op_q;
    logic        reg_wr_q;
    logic        wb_sel_q;
    logic        flag_wr_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic        illegal_q;
    logic        halted_q;

    kind_t       dec_kind;
    logic [2:0]  dec_op;
    logic        dec_wr;
    logic        dec_fw;

    // Decode the presented word so the result is ready to latch on handshake.
    always_comb begin
        dec_kind = K_ILL;
        dec_op   = 3'b000;
        dec_wr   = 1'b0;
        dec_fw   = 1'b0;
        if (instr == 16'h0000) begin
            dec_kind = K_EOF;
        end else if (instr[15:12] == 4'b0000) begin
            dec_kind = K_ALU;
            case (instr[7:4])
                4'b0101: begin dec_op = 3'b000; dec_wr = 1'b1; dec_fw = 1'b1; end
                4'b1001: begin dec_op = 3'b001; dec_wr = 1'b1; dec_fw = 1'b1; end
                4'b0001: begin dec_op = 3'b010; dec_wr = 1'b1; end
                4'b0010: begin dec_op = 3'b011; dec_wr = 1'b1; end
                4'b0011: begin dec_op = 3'b100; dec_wr = 1'b1; end
                4'b1101: begin dec_op = 3'b101; dec_wr = 1'b1; end
                4'b1011: begin dec_op = 3'b110; dec_fw = 1'b1; end
                default: dec_kind = K_ILL;
            endcase
        end else if (instr[15:12] == 4'b0100) begin
            if (instr[7:4] == 4'b0000) begin
                dec_kind = K_LOAD;
            end else if (instr[7:4] == 4'b0100) begin
                dec_kind = K_STOR;
            end
        end
    end

    // Controller FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            kind_q    <= K_ILL;
            ir        <= 16'h0000;
            cnt       <= 4'd0;
            ready_q   <= 1'b1;
            alu_wr_q  <= 1'b0;
            alu_fw_q  <= 1'b0;
            alu_op_q  <= 3'b000;
            reg_wr_q  <= 1'b0;
            wb_sel_q  <= 1'b0;
            flag_wr_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            // Strobes are single-state; each state re-asserts what it needs.
            reg_wr_q  <= 1'b0;
            wb_sel_q  <= 1'b0;
            flag_wr_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && ready_q) begin
                        state     <= S_DECODE;
                        ready_q   <= 1'b0;
                        ir        <= instr;
                        kind_q    <= dec_kind;
                        alu_wr_q  <= dec_wr;
                        alu_fw_q  <= dec_fw;
                        alu_op_q  <= (dec_kind == K_ALU) ? dec_op : 3'b000;
                        illegal_q <= (dec_kind == K_ILL);
                    end
                end
                S_DECODE: begin
                    case (kind_q)
                        K_ALU: begin
                            state <= S_EXEC;
                        end
                        K_LOAD: begin
                            state    <= S_MEM;
                            cnt      <= WAIT_LOAD;
                            mem_rd_q <= 1'b1;
                        end
                        K_STOR: begin
                            state    <= S_MEM;
                            cnt      <= WAIT_LOAD;
                            mem_wr_q <= 1'b1;
                        end
                        K_EOF: begin
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state    <= S_IDLE;
                            ready_q  <= 1'b1;
                            ir       <= 16'h0000;
                            alu_op_q <= 3'b000;
                        end
                    endcase
                end
                S_EXEC: begin
                    state     <= S_WB;
                    reg_wr_q  <= alu_wr_q;
                    flag_wr_q <= alu_fw_q;
                end
                S_MEM: begin
                    if (cnt == 4'd0) begin
                        if (kind_q == K_LOAD) begin
                            state    <= S_WB;
                            reg_wr_q <= 1'b1;
                            wb_sel_q <= 1'b1;
                        end else begin
                            state   <= S_IDLE;
                            ready_q <= 1'b1;
                            ir      <= 16'h0000;
                        end
                    end else begin
                        cnt      <= cnt - 4'd1;
                        mem_rd_q <= (kind_q == K_LOAD);
                        mem_wr_q <= (kind_q == K_STOR);
                    end
                end
                S_WB: begin
                    state    <= S_IDLE;
                    ready_q  <= 1'b1;
                    ir       <= 16'h0000;
                    alu_op_q <= 3'b000;
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // IR is cleared on every return to IDLE, so the address fields read 0 there.
    assign rdest_addr  = ir[11:8];
    assign rsrc_addr   = ir[3:0];
    assign instr_ready = ready_q & rst;
    assign alu_op      = alu_op_q;
    assign reg_wr_en   = reg_wr_q;
    assign wb_sel      = wb_sel_q;
    assign flag_wr_en  = flag_wr_q;
    assign mem_rd_en   = mem_rd_q;
    assign mem_wr_en   = mem_wr_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;
    assign dbg_state   = state;

endmodule
